// File: rtl/seq_bus_datapath.sv
// Single-bus datapath with an internal T-step sequencer: LDY, EXEC, WB/WBLO/WBHI, DONE; start is accepted only in IDLE.
// ALU done in cycle 4, mul in cycle 5 (4+DATA_W with SEQ_MUL_EN defined, iterative Booth), illegal op in cycle 1.
module seq_bus_datapath #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [RSEL_W-1:0] ra,
  input  logic [RSEL_W-1:0] rb,
  input  logic [RSEL_W-1:0] rc,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              ld_en,
  input  logic [RSEL_W-1:0] ld_sel,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_LDY, S_EXEC, S_WB, S_WBLO, S_WBHI, S_DONE} state_t;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
  localparam logic [4:0] OP_SHR = 5'd4, OP_SHRA = 5'd5, OP_SHL = 5'd6, OP_ROR = 5'd7;
  localparam logic [4:0] OP_ROL = 5'd8, OP_MUL = 5'd9, OP_NEG = 5'd10, OP_NOT = 5'd11;

  state_t              state_q, state_d;
  logic [4:0]          op_q, op_d;
  logic [RSEL_W-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   y_q, y_d, zh_q, zh_d, zl_q, zl_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [DATA_W-1:0]   bus, alu_hi, alu_lo;
  logic [SH_W-1:0]     sh;
  logic [2*DATA_W-1:0] rot_r, rot_l;

`ifdef SEQ_MUL_EN
  logic [DATA_W:0]     acc_q, acc_d, acc_n, a_sum, m_ext;
  logic [DATA_W-1:0]   mq_q, mq_d, mq_n;
  logic                q1_q, q1_d;
  logic [SH_W-1:0]     cnt_q, cnt_d;

  // One radix-2 Booth step: accumulator is one bit wider so the most negative multiplicand cannot overflow.
  always_comb begin
    m_ext = {bus[DATA_W-1], bus};
    case ({mq_q[0], q1_q})
      2'b01:   a_sum = acc_q + m_ext;
      2'b10:   a_sum = acc_q - m_ext;
      default: a_sum = acc_q;
    endcase
    acc_n = {a_sum[DATA_W], a_sum[DATA_W:1]};
    mq_n  = {a_sum[0], mq_q[DATA_W-1:1]};
  end
`else
  logic [2*DATA_W-1:0] prod;
  assign prod = $signed({{DATA_W{y_q[DATA_W-1]}}, y_q}) * $signed({{DATA_W{bus[DATA_W-1]}}, bus});
`endif

  // R0 is never written, so direct indexing already reads it as zero.
  always_comb begin
    case (state_q)
      S_LDY:         bus = regs_q[rb_q];
      S_EXEC:        bus = regs_q[rc_q];
      S_WB, S_WBLO:  bus = zl_q;
      S_WBHI:        bus = zh_q;
      default:       bus = '0;
    endcase
  end

  always_comb begin
    sh     = bus[SH_W-1:0];
    rot_r  = {y_q, y_q} >> sh;
    rot_l  = {y_q, y_q} << sh;
    alu_hi = '0;
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = y_q + bus;
      OP_SUB:  alu_lo = y_q - bus;
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_SHR:  alu_lo = y_q >> sh;
      OP_SHRA: alu_lo = $signed(y_q) >>> sh;
      OP_SHL:  alu_lo = y_q << sh;
      OP_ROR:  alu_lo = rot_r[DATA_W-1:0];
      OP_ROL:  alu_lo = rot_l[2*DATA_W-1:DATA_W];
`ifndef SEQ_MUL_EN
      OP_MUL:  {alu_hi, alu_lo} = prod;
`endif
      OP_NEG:  alu_lo = '0 - y_q;
      OP_NOT:  alu_lo = ~y_q;
      default: alu_lo = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    illegal_d = illegal_q;
    y_d       = y_q;
    zh_d      = zh_q;
    zl_d      = zl_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    regs_d    = regs_q;
`ifdef SEQ_MUL_EN
    acc_d     = acc_q;
    mq_d      = mq_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ld_en && ld_sel != '0) regs_d[ld_sel] = ld_data;
        if (start) begin
          op_d      = op;
          ra_d      = ra;
          rb_d      = rb;
          rc_d      = rc;
          illegal_d = (op > OP_NOT);
          state_d   = (op > OP_NOT) ? S_DONE : S_LDY;
        end
      end
      S_LDY: begin
        y_d     = bus;
        state_d = S_EXEC;
`ifdef SEQ_MUL_EN
        acc_d   = '0;
        mq_d    = bus;
        q1_d    = 1'b0;
        cnt_d   = '0;
`endif
      end
      S_EXEC: begin
`ifdef SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d = acc_n;
          mq_d  = mq_n;
          q1_d  = mq_q[0];
          cnt_d = cnt_q + 1'b1;
          zh_d  = acc_n[DATA_W-1:0];
          zl_d  = mq_n;
          if (cnt_q == '1) state_d = S_WBLO;
        end else begin
          zh_d    = alu_hi;
          zl_d    = alu_lo;
          state_d = S_WB;
        end
`else
        zh_d    = alu_hi;
        zl_d    = alu_lo;
        state_d = (op_q == OP_MUL) ? S_WBLO : S_WB;
`endif
      end
      S_WB: begin
        if (ra_q != '0) regs_d[ra_q] = bus;
        state_d = S_DONE;
      end
      S_WBLO: begin
        lo_d    = bus;
        state_d = S_WBHI;
      end
      S_WBHI: begin
        hi_d    = bus;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      illegal_q <= 1'b0;
      y_q       <= '0;
      zh_q      <= '0;
      zl_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef SEQ_MUL_EN
      acc_q     <= '0;
      mq_q      <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      illegal_q <= illegal_d;
      y_q       <= y_d;
      zh_q      <= zh_d;
      zl_q      <= zl_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      regs_q    <= regs_d;
`ifdef SEQ_MUL_EN
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_DONE) && illegal_q;
  assign dbg_data = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];
  assign bus_out  = bus;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
endmodule

// File: doc/seq_bus_datapath.md
Name: seq_bus_datapath

Overview:
- Parametrised, self-sequencing successor to the single-bus datapath.
- Register file, Y, Z (ZHigh/ZLow), HI and LO all share one internal bus, the same as the existing datapath.
- An internal T-step state machine generates the out/in strobes that the bench drove by hand before.
- Each accepted register-register instruction runs through load-Y, execute, write-back and done, with a start/busy/done handshake.

Parameters:
- DATA_W, 32, datapath width in bits; must be a power of 2, at least 8.
- NREGS, 16, number of general registers; a power of 2, at least 4. R0 always reads zero.
- RSEL_W, $clog2(NREGS), width of the register select fields.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- start  in  1  instruction request; sampled only in IDLE.
- op  in  5  ALU operation code.
- ra  in  RSEL_W  destination register.
- rb  in  RSEL_W  source A (loaded into Y).
- rc  in  RSEL_W  source B, or the shift amount for shift ops.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal op, coincident with done.
- ld_en  in  1  direct register load; honoured only in IDLE.
- ld_sel  in  RSEL_W  register to load.
- ld_data  in  DATA_W  value to load.
- dbg_sel  in  RSEL_W  debug read select.
- dbg_data  out  DATA_W  combinational read of the selected register; R0 reads 0.
- bus_out  out  DATA_W  current bus contents, for observation.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.

Behaviour:
- Reset: clr high at a clock edge clears all registers, Y, Z, HI and LO, and sets state to IDLE. busy, done and err are 0.
  - clr mid-instruction aborts it immediately; no write-back occurs.
- Opcodes:
  - 0 add, 1 sub (Y minus bus), 2 and, 3 or.
  - 4 shr (logical), 5 shra (arithmetic), 6 shl, 7 ror, 8 rol.
  - 9 mul (signed, full 2*DATA_W product).
  - 10 neg (-Y), 11 not (~Y).
  - 12 through 31 are illegal.
- Shift amount: the low $clog2(DATA_W) bits of the bus value only. A rotate by 0 is the identity.
- Arithmetic: add/sub wrap modulo 2^DATA_W; no flags. For non-mul ops ZHigh is 0.
- States: IDLE, LDY, EXEC, WB, WBLO, WBHI, DONE.
  - IDLE: start=1 goes to LDY. An illegal op goes straight to DONE with err=1 and no register changes.
  - LDY: bus = reg[rb]; Y <= bus; next state EXEC.
  - EXEC: bus = reg[rc]; {ZHigh, ZLow} <= ALU(Y, bus); next state WB, or WBLO for mul.
  - WB: bus = ZLow; reg[ra] <= bus unless ra == 0; next state DONE.
  - WBLO: bus = ZLow; LO <= bus; next state WBHI.
  - WBHI: bus = ZHigh; HI <= bus; next state DONE. mul never writes ra.
  - DONE: done=1; next state IDLE.
- Bus in idle states: 0 in IDLE and DONE.
- Latency, with start high in cycle 0:
  - ALU ops: done in cycle 4.
  - mul: done in cycle 5.
  - illegal op: done and err in cycle 1.
  - A new start is accepted in the cycle after done (back-to-back).
- Operands: ra, rb, rc and op are captured at acceptance. Later changes to them have no effect.
- Boundaries:
  - start while busy is ignored.
  - ld_en while busy is ignored.
  - ld_en and start in the same IDLE cycle: the load happens at that edge, so LDY/EXEC read the new value.
  - ld_sel == 0 is ignored.
  - ra == rb or ra == rc is legal; sources are read before write-back.

Optional Feature:
- Macro: SEQ_MUL_EN.
- Defined: mul is an iterative signed shift-add (Booth radix-2). EXEC lasts exactly DATA_W cycles, counted by an internal counter, with bus = reg[rc] held throughout. mul done arrives in cycle 4+DATA_W. The result is bit-identical to the combinational version.
- Undefined: single-cycle combinational multiply; EXEC lasts 1 cycle.

Test Plan:
- Add: load R3=5, R5=3; start op=0 ra=1 rb=3 rc=5 -> done in cycle 4, R1=8, busy high in cycles 1-4 only.
- Shifts: R6=0x80000010, R7=4; shra into R2 -> 0xF8000001; shr -> 0x08000001; ror by R7=36 -> amount 4, 0x08000001; rol by 0 -> 0x80000010 unchanged.
- Multiply: R6=-3 (0xFFFFFFFD), R7=7; mul -> LO=0xFFFFFFEB, HI=0xFFFFFFFF; done in cycle 5, or cycle 36 with SEQ_MUL_EN; R0-R15 unchanged.
- Write to R0: ra=0 add of 1+1 -> dbg_data for R0 stays 0. Same-cycle ld_en R3=9 with start add ra=4 rb=3 rc=3 -> R4=18.
- Illegal op and ignored start: op=20 -> done and err together in cycle 1, no state change. start pulsed during busy -> ignored, exactly one done.
- Reset mid-instruction: clr asserted during EXEC of add into R1 (R1=0x55 beforehand) -> next cycle busy=0, R1=0, Y, HI and LO are 0, no done pulse.
